imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Pipelined successor to the combinational immediate generator.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J, plus the shift-amount form) from a fetched instruction.
- Computes the pc-relative target and flags unknown opcodes.
- Sits between fetch and execute behind a valid/ready handshake, with an optional 2-entry skid buffer so backpressure never drops an instruction.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sign-extension width and shamt width follow it.
- SKID_EN, 1. 1 = 2-entry skid buffer with registered in_ready. 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill all held entries (branch redirect)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction, passed through
- out_pc  out  XLEN  pc, passed through
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  format code (imm_pkg::fmt_e)
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
- out_illegal  out  1  opcode not in decode table

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0; out_instr, out_pc, out_imm, out_target = 0; out_fmt=FMT_NONE; out_illegal=0; skid entries invalid. After reset, in_ready=1.
- Decode, applied to the accepted instruction. "sext" means sign-extend to XLEN.
  - Opcode 0000011 (LOAD), 1100111 (JALR), 1110011 (SYSTEM): I format, imm = sext(instr[31:20]).
  - Opcode 0010011 (OP-IMM): I format. When funct3=001 or 101, fmt=FMT_SH and imm = zero-extended shamt: instr[24:20] for XLEN=32, instr[25:20] for XLEN=64. Funct7 bits are excluded from imm.
  - Opcode 0100011: S format, imm = sext({instr[31:25], instr[11:7]}).
  - Opcode 1100011: B format, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - Opcodes 0110111 and 0010111: U format, imm = sext({instr[31:12], 12'b0}).
  - Opcode 1101111: J format, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Opcode 0110011: FMT_R, imm = 0, illegal = 0.
  - Any other opcode: FMT_NONE, imm = 0, illegal = 1. The entry still flows through the stage and is not dropped.
- target = pc + imm, computed for every format and truncated to XLEN. Consumers use it only for B, J and AUIPC.
- Latency: exactly 1 cycle from acceptance (in_valid and in_ready at an edge) to out_valid, when no older entry is ahead.
- Handshake:
  - Transfer happens only when valid and ready are both high at an edge.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - in_valid is never required to depend on in_ready.
- SKID_EN=1:
  - in_ready is a register output, equal to "skid entry empty".
  - If the output entry stalls while a new input is accepted, that input goes to the skid entry and in_ready drops next cycle.
  - When the output entry drains, the skid entry moves to the output in the same edge and in_ready returns high next cycle.
  - Order is strictly FIFO; sustained throughput is 1 per cycle.
- SKID_EN=0: in_ready = !out_valid || out_ready, combinational.
- Simultaneous output drain and input accept: the output entry is replaced in place and remains valid.
- flush=1 at an edge:
  - All entries are invalidated and out_valid=0 next cycle.
  - An input accepted on that same edge is discarded.
  - in_ready=1 next cycle.
  - flush has priority over every handshake event. Data registers are not cleared.
- rst_n low mid-stream discards all entries, identical to the reset values above.

Decomposition:
- imm_pkg holds the opcode localparams, fmt_e (FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J), and a packed stage_entry_t struct {instr, pc, imm, fmt, target, illegal}.
- One combinational sub-module, imm_extract (instr -> imm, fmt, illegal; parametrised by XLEN), is instanced once on the input side.
- The top level owns the registers, the skid buffer and the target adder.

Test Plan:
- Branch decode (XLEN=32): in_instr=0xFE000EE3 (beq -4), in_pc=0x100 -> one cycle later out_fmt=FMT_B, out_imm=0xFFFFFFFC, out_target=0x000000FC, out_illegal=0.
- U-type at XLEN=64:
  - in_instr=0x123450B7 -> out_imm=0x0000000012345000.
  - in_instr=0x800000B7 -> out_imm=0xFFFFFFFF80000000.
- J format and shift amount:
  - in_instr=0x0080006F, in_pc=0x200 -> out_imm=8, out_target=0x208.
  - in_instr=0x4030D093 (srai x1,x1,3) -> out_fmt=FMT_SH, out_imm=3.
- Backpressure (SKID_EN=1):
  - Stimulus: drive 4 back-to-back instructions A, B, C, D with out_ready=0 for 3 cycles, then out_ready=1.
  - Required: in_ready falls after A and B are held; A, B, C, D emerge in order with no loss and no duplication; out_* is stable during the stall.
  - Repeat with SKID_EN=0: in_ready follows out_ready combinationally.
- Flush:
  - Stimulus: with 2 entries held, assert flush on the same edge as a new accept.
  - Required: out_valid=0 next cycle, the accepted input never appears at the output, in_ready=1.
  - Repeat the scenario using rst_n=0 instead of flush: all outputs take their reset values.
- Illegal opcode: in_instr=0x0000007F -> out_illegal=1, out_fmt=FMT_NONE, out_imm=0, and the entry completes the handshake normally.

Source files
------------

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcodes, format codes and entry record for the immediate decode stage
package imm_pkg;

    // Widest supported datapath; the full-width entry record is sized to it.
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_SH   = 3'd3,
        FMT_S    = 3'd4,
        FMT_B    = 3'd5,
        FMT_U    = 3'd6,
        FMT_J    = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] target;
        logic                illegal;
    } stage_entry_t;

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate and format extraction from one instruction
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    // Shift amounts are 5 bits on RV32 and 6 bits on RV64.
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    // Every sign-extended immediate fits in 32 bits, so it is built signed
    // at 32 bits and widened once.
    logic signed [31:0] simm;

    // Opcode decode; the widening cast sign-extends because simm is signed.
    always_comb begin
        simm      = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                fmt_o = FMT_I;
                simm  = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_OP_IMM: begin
                fmt_o = (instr_i[13:12] == 2'b01) ? FMT_SH : FMT_I;
                simm  = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                simm  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                simm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                simm  = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                simm  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt_o = FMT_R;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
        imm_o = XLEN'(simm);
        // funct3 001/101 selects the shift form; funct7 stays out of imm.
        if (fmt_o == FMT_SH) begin
            imm_o = XLEN'(instr_i[20 +: SHW]);
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate decode stage with optional 2-entry skid buffer
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output fmt_e            out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{instr: '0, pc: '0, imm: '0, fmt: FMT_NONE,
                                     target: '0, illegal: 1'b0};

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    entry_t          in_e;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_vld_q, out_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   rdy_q, rdy_d;
    logic   accept;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    // Package the incoming instruction with its decode and pc-relative target.
    always_comb begin
        in_e.instr   = in_instr;
        in_e.pc      = in_pc;
        in_e.imm     = dec_imm;
        in_e.fmt     = dec_fmt;
        in_e.target  = in_pc + dec_imm;
        in_e.illegal = dec_illegal;
    end

    // With the skid buffer, ready is a flop (skid empty); without it, ready
    // looks through to the downstream consumer.
    assign in_ready = SKID_EN ? rdy_q : (!out_vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state: flush wins; a free output slot takes the skid entry first,
    // otherwise the new input; a stalled slot parks the new input in skid.
    // The skid path is only ever reached when SKID_EN=1 because a stalled
    // slot forces in_ready low otherwise.
    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || out_ready) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = in_e;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_e;
            skid_vld_d = 1'b1;
        end
        rdy_d = !skid_vld_d;
    end

    // State and entry registers; flush drops valids but leaves data in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q      <= ENTRY_RST;
            skid_q     <= ENTRY_RST;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign out_valid   = out_vld_q;
    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_target  = out_q.target;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - scoreboard bench for the immediate decode stage (RV32 skid, RV64 no-skid)
`timescale 1ns/1ps
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst_n, a_flush, b_flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc, a_out_imm, a_out_target;
    fmt_e        a_out_fmt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_instr, b_out_instr;
    logic [63:0] b_in_pc, b_out_pc, b_out_imm, b_out_target;
    fmt_e        b_out_fmt;

    imm_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
        .out_pc(a_out_pc), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
        .out_target(a_out_target), .out_illegal(a_out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .SKID_EN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
        .out_target(b_out_target), .out_illegal(b_out_illegal)
    );

    int tests = 0;
    int fails = 0;
    stage_entry_t a_q[$];
    stage_entry_t b_q[$];

    stage_entry_t a_now, b_now;
    assign a_now = {a_out_instr, 32'b0, a_out_pc, 32'b0, a_out_imm, a_out_fmt,
                    32'b0, a_out_target, a_out_illegal};
    assign b_now = {b_out_instr, b_out_pc, b_out_imm, b_out_fmt, b_out_target, b_out_illegal};

    function automatic stage_entry_t mk(logic [31:0] i, logic [63:0] p, logic [63:0] m,
                                        fmt_e f, logic [63:0] t, logic il);
        mk = '{instr: i, pc: p, imm: m, fmt: f, target: t, illegal: il};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_entry(string name, stage_entry_t act, stage_entry_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got instr=%h pc=%h imm=%h fmt=%0d tgt=%h ill=%b, expected instr=%h pc=%h imm=%h fmt=%0d tgt=%h ill=%b",
                     name, act.instr, act.pc, act.imm, act.fmt, act.target, act.illegal,
                     exp.instr, exp.pc, exp.imm, exp.fmt, exp.target, exp.illegal);
        end
    endtask

    // Monitor A: pops on each transfer, and checks stalled outputs stay put.
    stage_entry_t a_snap;
    logic a_stalled = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || a_flush) begin
            a_stalled <= 1'b0;
        end else begin
            if (a_stalled) begin
                chk("a_hold_valid", 64'(a_out_valid), 64'd1);
                chk_entry("a_hold_stable", a_now, a_snap);
            end
            if (a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_output: got instr=%h, expected no output", a_out_instr);
                end else begin
                    chk_entry("a_out", a_now, a_q.pop_front());
                end
            end
            a_stalled <= a_out_valid && !a_out_ready;
            a_snap    <= a_now;
        end
    end

    // Monitor B: same checks for the RV64 no-skid instance.
    stage_entry_t b_snap;
    logic b_stalled = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || b_flush) begin
            b_stalled <= 1'b0;
        end else begin
            if (b_stalled) begin
                chk("b_hold_valid", 64'(b_out_valid), 64'd1);
                chk_entry("b_hold_stable", b_now, b_snap);
            end
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_output: got instr=%h, expected no output", b_out_instr);
                end else begin
                    chk_entry("b_out", b_now, b_q.pop_front());
                end
            end
            b_stalled <= b_out_valid && !b_out_ready;
            b_snap    <= b_now;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic a_send(logic [31:0] instr, logic [31:0] pc, stage_entry_t e);
        a_in_valid = 1'b1; a_in_instr = instr; a_in_pc = pc;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (a_in_ready) begin
                a_q.push_back(e);
                @(posedge clk); #1;
                a_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++; fails++;
        $display("FAIL a_send_timeout: in_ready=%b, expected 1", a_in_ready);
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(logic [31:0] instr, logic [63:0] pc, stage_entry_t e);
        b_in_valid = 1'b1; b_in_instr = instr; b_in_pc = pc;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (b_in_ready) begin
                b_q.push_back(e);
                @(posedge clk); #1;
                b_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++; fails++;
        $display("FAIL b_send_timeout: in_ready=%b, expected 1", b_in_ready);
        b_in_valid = 1'b0;
    endtask

    task automatic drain(string name);
        for (int n = 0; n < 20 && (a_q.size() != 0 || b_q.size() != 0); n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({name, "_queue_empty"}, 64'(a_q.size() + b_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_a_reset(string name);
        chk({name, "_valid"},   64'(a_out_valid),   64'd0);
        chk({name, "_ready"},   64'(a_in_ready),    64'd1);
        chk({name, "_instr"},   64'(a_out_instr),   64'd0);
        chk({name, "_pc"},      64'(a_out_pc),      64'd0);
        chk({name, "_imm"},     64'(a_out_imm),     64'd0);
        chk({name, "_fmt"},     64'(a_out_fmt),     64'(FMT_NONE));
        chk({name, "_target"},  64'(a_out_target),  64'd0);
        chk({name, "_illegal"}, 64'(a_out_illegal), 64'd0);
    endtask

    int c0;

    initial begin
        rst_n = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
        a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_a_reset("a_reset");
        chk("b_reset_valid", 64'(b_out_valid), 64'd0);
        chk("b_reset_ready", 64'(b_in_ready), 64'd1);
        chk("b_reset_imm", b_out_imm, 64'd0);
        @(posedge clk); #1;

        // RV32 decode: single-cycle latency, then back-to-back formats.
        a_send(32'hFE000EE3, 32'h100, mk(32'hFE000EE3, 64'h100, 64'hFFFFFFFC, FMT_B, 64'hFC, 1'b0));
        @(negedge clk);
        chk("a_latency_valid", 64'(a_out_valid), 64'd1);
        @(posedge clk); #1;
        c0 = cyc;
        a_send(32'h0080006F, 32'h200, mk(32'h0080006F, 64'h200, 64'h8, FMT_J, 64'h208, 1'b0));
        a_send(32'h4030D093, 32'h300, mk(32'h4030D093, 64'h300, 64'h3, FMT_SH, 64'h303, 1'b0));
        a_send(32'h0000007F, 32'h400, mk(32'h0000007F, 64'h400, 64'h0, FMT_NONE, 64'h400, 1'b1));
        a_send(32'hFFF12083, 32'h500, mk(32'hFFF12083, 64'h500, 64'hFFFFFFFF, FMT_I, 64'h4FF, 1'b0));
        a_send(32'hFE20AC23, 32'h600, mk(32'hFE20AC23, 64'h600, 64'hFFFFFFF8, FMT_S, 64'h5F8, 1'b0));
        a_send(32'h123450B7, 32'h700, mk(32'h123450B7, 64'h700, 64'h12345000, FMT_U, 64'h12345700, 1'b0));
        a_send(32'h00001097, 32'h800, mk(32'h00001097, 64'h800, 64'h1000, FMT_U, 64'h1800, 1'b0));
        a_send(32'h002081B3, 32'h900, mk(32'h002081B3, 64'h900, 64'h0, FMT_R, 64'h900, 1'b0));
        a_send(32'hFFF00093, 32'h900, mk(32'hFFF00093, 64'h900, 64'hFFFFFFFF, FMT_I, 64'h8FF, 1'b0));
        chk("a_throughput_cycles", 64'(cyc - c0), 64'd9);
        drain("a_decode");

        // Backpressure with skid: A, B, C, D against three stalled cycles.
        fork
            begin
                a_send(32'h00A00093, 32'h1000, mk(32'h00A00093, 64'h1000, 64'hA, FMT_I, 64'h100A, 1'b0));
                a_send(32'hFE000EE3, 32'h1004, mk(32'hFE000EE3, 64'h1004, 64'hFFFFFFFC, FMT_B, 64'h1000, 1'b0));
                a_send(32'h0080006F, 32'h1008, mk(32'h0080006F, 64'h1008, 64'h8, FMT_J, 64'h1010, 1'b0));
                a_send(32'h0000007F, 32'h100C, mk(32'h0000007F, 64'h100C, 64'h0, FMT_NONE, 64'h100C, 1'b1));
            end
            begin
                a_out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("a_bp_ready_low", 64'(a_in_ready), 64'd0);
                chk("a_bp_head_is_A", 64'(a_out_instr), 64'h00A00093);
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
        join
        drain("a_bp");

        // Flush with output and skid both occupied; stray input offered too.
        a_out_ready = 1'b0;
        a_send(32'h00100093, 32'h2000, mk(32'h00100093, 64'h2000, 64'h1, FMT_I, 64'h2001, 1'b0));
        a_send(32'h00200093, 32'h2004, mk(32'h00200093, 64'h2004, 64'h2, FMT_I, 64'h2006, 1'b0));
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 32'h00300093; a_in_pc = 32'h2008;
        @(negedge clk);
        a_q.delete();
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        @(negedge clk);
        chk("a_flush2_valid", 64'(a_out_valid), 64'd0);
        chk("a_flush2_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;

        // Flush on the same edge as an accepted input: that input must vanish.
        a_send(32'h00400093, 32'h3000, mk(32'h00400093, 64'h3000, 64'h4, FMT_I, 64'h3004, 1'b0));
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 32'h00500093; a_in_pc = 32'h3004;
        @(negedge clk);
        chk("a_flush_accept_ready", 64'(a_in_ready), 64'd1);
        a_q.delete();
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("a_flush1_valid", 64'(a_out_valid), 64'd0);
        chk("a_flush1_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        a_send(32'h00600093, 32'h3100, mk(32'h00600093, 64'h3100, 64'h6, FMT_I, 64'h3106, 1'b0));
        drain("a_flush");

        // Reset mid-stream with two entries held and an input offered.
        a_out_ready = 1'b0;
        a_send(32'h00700093, 32'h4000, mk(32'h00700093, 64'h4000, 64'h7, FMT_I, 64'h4007, 1'b0));
        a_send(32'h00800093, 32'h4004, mk(32'h00800093, 64'h4004, 64'h8, FMT_I, 64'h400C, 1'b0));
        rst_n = 1'b0; a_in_valid = 1'b1; a_in_instr = 32'h00900093; a_in_pc = 32'h4008;
        @(negedge clk);
        a_q.delete(); b_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; a_in_valid = 1'b0;
        @(negedge clk);
        chk_a_reset("a_midreset");
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        drain("a_reset");

        // RV64 decode, including U sign extension and the 6-bit shamt.
        b_send(32'h123450B7, 64'h1000, mk(32'h123450B7, 64'h1000, 64'h0000000012345000, FMT_U, 64'h12346000, 1'b0));
        b_send(32'h800000B7, 64'h10, mk(32'h800000B7, 64'h10, 64'hFFFFFFFF80000000, FMT_U, 64'hFFFFFFFF80000010, 1'b0));
        b_send(32'h02109093, 64'h20, mk(32'h02109093, 64'h20, 64'd33, FMT_SH, 64'h41, 1'b0));
        b_send(32'hFE000EE3, 64'h100, mk(32'hFE000EE3, 64'h100, 64'hFFFFFFFFFFFFFFFC, FMT_B, 64'hFC, 1'b0));

        // No-skid backpressure: in_ready tracks out_ready within the cycle.
        b_send(32'h00A00093, 64'h40, mk(32'h00A00093, 64'h40, 64'hA, FMT_I, 64'h4A, 1'b0));
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_instr = 32'hFFF00093; b_in_pc = 64'h44;
        @(negedge clk);
        chk("b_ready_follows_low", 64'(b_in_ready), 64'd0);
        #2 b_out_ready = 1'b1;
        #1 chk("b_ready_follows_high", 64'(b_in_ready), 64'd1);
        b_out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_ready_stall_low", 64'(b_in_ready), 64'd0);
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        b_send(32'hFFF00093, 64'h44, mk(32'hFFF00093, 64'h44, 64'hFFFFFFFFFFFFFFFF, FMT_I, 64'h43, 1'b0));
        b_send(32'h0000007F, 64'h48, mk(32'h0000007F, 64'h48, 64'h0, FMT_NONE, 64'h48, 1'b1));
        drain("b_all");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
